// File: rtl/crc_pkg.sv
// Shared definitions for the CRC engine: FSM encoding, legal configuration
// limits and the bit-reflection helper.
package crc_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } crc_state_e;

  localparam int unsigned CRC_W_MIN = 8;
  localparam int unsigned CRC_W_MAX = 32;
  localparam int unsigned LANES_MIN = 1;
  localparam int unsigned LANES_MAX = 4;

  // Reverses the low 'width' bits of val; bits at and above 'width' come back zero.
  function automatic logic [31:0] reflect_bits(input logic [31:0] val, input int unsigned width);
    logic [31:0] res;
    logic [4:0]  idx;
    res = 32'd0;
    for (int i = 0; i < 32; i++) begin
      idx = 5'(width - 32'd1 - 32'(i));
      if (i < int'(width)) begin
        res[i] = val[idx];
      end else begin
        res[i] = 1'b0;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/crc_byte_step.sv
// One byte of MSB-first CRC update: (register, byte) -> next register.
// Purely combinational so several copies can be chained within one beat.
module crc_byte_step
  import crc_pkg::*;
#(
  parameter int unsigned          CRC_W = 8,
  parameter logic [CRC_W-1:0]     POLY  = 8'h07
) (
  input  logic [CRC_W-1:0] crc_i,
  input  logic [7:0]       byte_i,
  output logic [CRC_W-1:0] crc_o
);

  logic [CRC_W-1:0] step_s;

  // Fold the byte into the top of the register, then shift out eight bits.
  always_comb begin
    step_s = crc_i;
    step_s[CRC_W-1 -: 8] = crc_i[CRC_W-1 -: 8] ^ byte_i;
    for (int b = 0; b < 8; b++) begin
      if (step_s[CRC_W-1]) begin
        step_s = {step_s[CRC_W-2:0], 1'b0} ^ POLY;
      end else begin
        step_s = {step_s[CRC_W-2:0], 1'b0};
      end
    end
  end

  assign crc_o = step_s;

endmodule

// File: rtl/crc_engine.sv
// Streaming CRC engine: up to four bytes per beat, configurable polynomial,
// init, reflection and final XOR, with a registered result handshake.
module crc_engine
  import crc_pkg::*;
#(
  parameter int unsigned CRC_W       = 8,
  parameter logic [31:0] POLY        = 32'h0000_0007,
  parameter logic [31:0] INIT        = 32'h0000_0000,
  parameter logic [31:0] XOR_OUT     = 32'h0000_0000,
  parameter bit          REFLECT_IN  = 1'b0,
  parameter bit          REFLECT_OUT = 1'b0,
  parameter int unsigned LANES       = 1,
  parameter logic [31:0] RESIDUE     = 32'h0000_0000
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic                 clr_i,
  input  logic [8*LANES-1:0]   s_data_i,
  input  logic [LANES-1:0]     s_keep_i,
  input  logic                 s_valid_i,
  input  logic                 s_last_i,
  output logic                 s_ready_o,
  output logic [CRC_W-1:0]     crc_o,
  output logic                 crc_valid_o,
  input  logic                 crc_ready_i,
  output logic                 crc_ok_o
);

  localparam logic [CRC_W-1:0] POLY_C    = POLY[CRC_W-1:0];
  localparam logic [CRC_W-1:0] INIT_C    = INIT[CRC_W-1:0];
  localparam logic [CRC_W-1:0] XOR_C     = XOR_OUT[CRC_W-1:0];
  localparam logic [CRC_W-1:0] RESIDUE_C = RESIDUE[CRC_W-1:0];

  if ((CRC_W != 8 && CRC_W != 16 && CRC_W != 32) || CRC_W < CRC_W_MIN || CRC_W > CRC_W_MAX ||
      LANES < LANES_MIN || LANES > LANES_MAX) begin : g_bad_cfg
    $error("crc_engine: illegal CRC_W or LANES");
  end

  crc_state_e       state_q, state_d;
  logic [CRC_W-1:0] reg_q, reg_d;
  logic [CRC_W-1:0] out_q, out_d;
  logic             ok_q, ok_d;
  logic             valid_q, valid_d;

  logic             accept_s;
  logic [LANES-1:0] lane_en_s;
  logic [CRC_W-1:0] chain_s [LANES+1];
  logic [CRC_W-1:0] final_s;

  assign s_ready_o = !valid_q || crc_ready_i;
  assign accept_s  = s_valid_i && s_ready_o;

  // A beat taken outside ACCUM opens a new frame, so it starts from INIT.
  assign chain_s[0] = (state_q == ST_ACCUM) ? reg_q : INIT_C;
  assign lane_en_s  = s_last_i ? s_keep_i : {LANES{1'b1}};

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [7:0]       byte_s;
    logic [CRC_W-1:0] step_s;

    assign byte_s = REFLECT_IN ? 8'(reflect_bits({24'd0, s_data_i[8*i +: 8]}, 32'd8))
                               : s_data_i[8*i +: 8];

    crc_byte_step #(
      .CRC_W (CRC_W),
      .POLY  (POLY_C)
    ) u_step (
      .crc_i  (chain_s[i]),
      .byte_i (byte_s),
      .crc_o  (step_s)
    );

    assign chain_s[i+1] = lane_en_s[i] ? step_s : chain_s[i];
  end

  assign final_s = CRC_W'(REFLECT_OUT ? reflect_bits(32'(chain_s[LANES]), CRC_W)
                                      : 32'(chain_s[LANES])) ^ XOR_C;

  // State, running register and result registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_IDLE;
      reg_q   <= INIT_C;
      out_q   <= '0;
      ok_q    <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      reg_q   <= reg_d;
      out_q   <= out_d;
      ok_q    <= ok_d;
      valid_q <= valid_d;
    end
  end

  // Next state; clr_i outranks any beat presented in the same cycle.
  always_comb begin
    state_d = state_q;
    reg_d   = reg_q;
    out_d   = out_q;
    ok_d    = ok_q;
    valid_d = valid_q;
    if (clr_i) begin
      state_d = ST_IDLE;
      reg_d   = INIT_C;
      valid_d = 1'b0;
    end else if (accept_s) begin
      if (s_last_i) begin
        state_d = ST_DONE;
        reg_d   = INIT_C;
        out_d   = final_s;
        ok_d    = (final_s == RESIDUE_C);
        valid_d = 1'b1;
      end else begin
        state_d = ST_ACCUM;
        reg_d   = chain_s[LANES];
        valid_d = 1'b0;
      end
    end else begin
      case (state_q)
        ST_DONE: begin
          if (crc_ready_i) begin
            state_d = ST_IDLE;
            valid_d = 1'b0;
          end else begin
            state_d = ST_DONE;
            valid_d = 1'b1;
          end
        end
        default: begin
          state_d = state_q;
        end
      endcase
    end
  end

  assign crc_o       = out_q;
  assign crc_ok_o    = ok_q;
  assign crc_valid_o = valid_q;

endmodule

// File: tb/tb_crc_engine.sv
// Bench for crc_engine: three configurations (CRC-8, CRC-16/CCITT, CRC-32)
// checked every cycle against a bit-serial reference model, plus known check values.
module tb_crc_engine;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic        clr_i = 1'b0;
  logic        crc_ready = 1'b1;
  logic        s_last = 1'b0;
  logic [31:0] s_data = 32'd0;
  logic [3:0]  s_keep = 4'd0;
  logic        vld  [3] = '{1'b0, 1'b0, 1'b0};
  logic        rdy  [3];
  logic        cval [3];
  logic        cok  [3];
  logic [7:0]  c8;
  logic [15:0] c16;
  logic [31:0] c32;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  bit rnd_en = 1'b0;
  logic [7:0] fq [$];

  int unsigned cw    [3] = '{8, 16, 32};
  logic [31:0] cpoly [3] = '{32'h07, 32'h1021, 32'h04C11DB7};
  logic [31:0] cinit [3] = '{32'h0, 32'hFFFF, 32'hFFFFFFFF};
  logic [31:0] cxo   [3] = '{32'h0, 32'h0, 32'hFFFFFFFF};
  bit          cri   [3] = '{1'b0, 1'b0, 1'b1};
  bit          cro   [3] = '{1'b0, 1'b0, 1'b1};
  int          cln   [3] = '{1, 2, 4};
  logic [31:0] cres  [3] = '{32'h0, 32'h0, 32'h2144DF1C};

  logic [31:0] m_reg [3] = '{32'd0, 32'd0, 32'd0};
  logic [31:0] m_crc [3] = '{32'd0, 32'd0, 32'd0};
  bit m_open  [3] = '{1'b0, 1'b0, 1'b0};
  bit m_valid [3] = '{1'b0, 1'b0, 1'b0};
  bit m_ok    [3] = '{1'b0, 1'b0, 1'b0};

  always #5 clk = ~clk;

  crc_engine #(.CRC_W(8), .POLY(32'h07), .INIT(32'h0), .XOR_OUT(32'h0), .REFLECT_IN(1'b0),
               .REFLECT_OUT(1'b0), .LANES(1), .RESIDUE(32'h0)) u_dut8 (
    .clk_i(clk), .rst_i(rst_i), .clr_i(clr_i), .s_data_i(s_data[7:0]), .s_keep_i(s_keep[0:0]),
    .s_valid_i(vld[0]), .s_last_i(s_last), .s_ready_o(rdy[0]), .crc_o(c8),
    .crc_valid_o(cval[0]), .crc_ready_i(crc_ready), .crc_ok_o(cok[0]));

  crc_engine #(.CRC_W(16), .POLY(32'h1021), .INIT(32'hFFFF), .XOR_OUT(32'h0), .REFLECT_IN(1'b0),
               .REFLECT_OUT(1'b0), .LANES(2), .RESIDUE(32'h0)) u_dut16 (
    .clk_i(clk), .rst_i(rst_i), .clr_i(clr_i), .s_data_i(s_data[15:0]), .s_keep_i(s_keep[1:0]),
    .s_valid_i(vld[1]), .s_last_i(s_last), .s_ready_o(rdy[1]), .crc_o(c16),
    .crc_valid_o(cval[1]), .crc_ready_i(crc_ready), .crc_ok_o(cok[1]));

  crc_engine #(.CRC_W(32), .POLY(32'h04C11DB7), .INIT(32'hFFFFFFFF), .XOR_OUT(32'hFFFFFFFF),
               .REFLECT_IN(1'b1), .REFLECT_OUT(1'b1), .LANES(4), .RESIDUE(32'h2144DF1C)) u_dut32 (
    .clk_i(clk), .rst_i(rst_i), .clr_i(clr_i), .s_data_i(s_data), .s_keep_i(s_keep),
    .s_valid_i(vld[2]), .s_last_i(s_last), .s_ready_o(rdy[2]), .crc_o(c32),
    .crc_valid_o(cval[2]), .crc_ready_i(crc_ready), .crc_ok_o(cok[2]));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] wmask(input int unsigned w);
    return (w >= 32) ? 32'hFFFFFFFF : ((32'd1 << w) - 32'd1);
  endfunction

  // Reference: textbook bit-at-a-time CRC with feedback = top bit XOR data bit.
  function automatic logic [31:0] m_byte(input int unsigned w, input logic [31:0] poly, input bit refin,
                                         input logic [31:0] r, input logic [7:0] b);
    logic [7:0] bb;
    bit fb;
    for (int i = 0; i < 8; i++) bb[i] = refin ? b[7-i] : b[i];
    for (int k = 7; k >= 0; k--) begin
      fb = r[w-1] ^ bb[k];
      r  = (r << 1) & wmask(w);
      if (fb) r = r ^ (poly & wmask(w));
    end
    return r;
  endfunction

  function automatic logic [31:0] m_final(input int unsigned w, input bit refout,
                                          input logic [31:0] xo, input logic [31:0] r);
    logic [31:0] t;
    t = 32'd0;
    if (refout) begin
      for (int i = 0; i < int'(w); i++) t[i] = r[int'(w)-1-i];
    end else begin
      t = r;
    end
    return (t ^ xo) & wmask(w);
  endfunction

  function automatic logic [31:0] act_crc(input int d);
    case (d)
      0: return {24'd0, c8};
      1: return {16'd0, c16};
      default: return c32;
    endcase
  endfunction

  function automatic logic rdy_of(input int d);
    return rdy[d];
  endfunction

  task automatic model_reset();
    for (int d = 0; d < 3; d++) begin
      m_open[d] = 1'b0; m_valid[d] = 1'b0; m_ok[d] = 1'b0; m_crc[d] = 32'd0; m_reg[d] = cinit[d];
    end
  endtask

  task automatic model_step(input int d);
    bit acc;
    acc = vld[d] && (!m_valid[d] || crc_ready);
    if (clr_i) begin
      m_valid[d] = 1'b0;
      m_open[d]  = 1'b0;
    end else if (acc) begin
      if (!m_open[d]) m_reg[d] = cinit[d];
      for (int i = 0; i < cln[d]; i++)
        if (!s_last || s_keep[i]) m_reg[d] = m_byte(cw[d], cpoly[d], cri[d], m_reg[d], s_data[8*i +: 8]);
      if (s_last) begin
        m_crc[d]   = m_final(cw[d], cro[d], cxo[d], m_reg[d]);
        m_ok[d]    = (m_crc[d] == cres[d]);
        m_valid[d] = 1'b1;
        m_open[d]  = 1'b0;
      end else begin
        m_open[d]  = 1'b1;
        m_valid[d] = 1'b0;
      end
    end else if (crc_ready) begin
      m_valid[d] = 1'b0;
    end
  endtask

  // Model advances on the clock edge; DUT outputs are compared mid-cycle.
  always begin
    @(posedge clk);
    if (rst_i) model_reset();
    else for (int d = 0; d < 3; d++) model_step(d);
    @(negedge clk);
    if (rst_i) model_reset();
    if (chk_en) begin
      for (int d = 0; d < 3; d++) begin
        chk($sformatf("dut%0d_valid", d), 32'(cval[d]), 32'(m_valid[d]));
        chk($sformatf("dut%0d_ready", d), 32'(rdy[d]), 32'(!m_valid[d] || crc_ready));
        chk($sformatf("dut%0d_crc", d), act_crc(d), m_crc[d]);
        chk($sformatf("dut%0d_ok", d), 32'(cok[d]), 32'(m_ok[d]));
      end
    end
  end

  task automatic send_beat(input int d, input logic [31:0] data, input logic [3:0] keep, input bit last);
    bit acc;
    acc = 1'b0;
    s_data = data; s_keep = keep; s_last = last; vld[d] = 1'b1;
    for (int t = 0; t < 100 && !acc; t++) begin
      if (rnd_en) begin
        crc_ready = ($urandom_range(0, 9) < 7);
        clr_i     = ($urandom_range(0, 39) == 0);
      end
      @(negedge clk);
      acc = rdy_of(d) && !clr_i;
      @(posedge clk); #1;
      clr_i = 1'b0;
    end
    vld[d] = 1'b0; s_last = 1'b0;
    if (!acc) begin
      checks++; errors++;
      $display("FAIL dut%0d_beat_timeout got=stalled expected=accepted", d);
    end
  endtask

  task automatic send_frame(input int d);
    logic [31:0] w;
    logic [3:0]  k;
    int r;
    while (fq.size() > cln[d]) begin
      w = 32'd0;
      for (int i = 0; i < cln[d]; i++) w[8*i +: 8] = fq.pop_front();
      send_beat(d, w, 4'hF, 1'b0);
    end
    r = fq.size(); w = 32'd0; k = 4'd0;
    for (int i = 0; i < r; i++) begin
      w[8*i +: 8] = fq.pop_front();
      k[i] = 1'b1;
    end
    send_beat(d, w, k, 1'b1);
  endtask

  task automatic load_check();
    fq = {};
    for (int i = 0; i < 9; i++) fq.push_back(8'h31 + 8'(i));
  endtask

  task automatic expect_result(input int d, input string name, input logic [31:0] exp);
    @(negedge clk);
    chk({name, "_valid"}, 32'(cval[d]), 32'd1);
    chk(name, act_crc(d), exp);
    @(posedge clk); #1;
  endtask

  task automatic check_reset_state(input string name);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      chk($sformatf("%s_valid%0d", name, d), 32'(cval[d]), 32'd0);
      chk($sformatf("%s_crc%0d", name, d), act_crc(d), 32'd0);
      chk($sformatf("%s_ok%0d", name, d), 32'(cok[d]), 32'd0);
      chk($sformatf("%s_ready%0d", name, d), 32'(rdy[d]), 32'd1);
    end
    @(posedge clk); #1;
  endtask

  initial begin
    logic [31:0] r;
    logic [31:0] lit [3] = '{32'hF4, 32'h29B1, 32'hCBF43926};
    repeat (3) @(posedge clk);
    #1 rst_i = 1'b0;
    chk_en = 1'b1;
    check_reset_state("reset");

    // Pin the reference model to the published check values.
    for (int d = 0; d < 3; d++) begin
      r = cinit[d];
      for (int i = 0; i < 9; i++) r = m_byte(cw[d], cpoly[d], cri[d], r, 8'h31 + 8'(i));
      chk($sformatf("model_check%0d", d), m_final(cw[d], cro[d], cxo[d], r), lit[d]);
    end

    load_check(); send_frame(0); expect_result(0, "crc8_check", 32'hF4);
    load_check(); send_frame(1); expect_result(1, "crc16_check", 32'h29B1);
    load_check(); send_frame(2); expect_result(2, "crc32_check", 32'hCBF43926);

    send_beat(1, 32'h0000A5A5, 4'h0, 1'b1); expect_result(1, "crc16_empty", 32'hFFFF);
    send_beat(2, 32'h5A5A5A5A, 4'h0, 1'b1); expect_result(2, "crc32_empty", 32'h0);

    load_check(); fq.push_back(8'hF4); send_frame(0);
    @(negedge clk);
    chk("residue_crc", act_crc(0), 32'h0);
    chk("residue_ok", 32'(cok[0]), 32'd1);
    @(posedge clk); #1;
    load_check(); fq[4] = 8'h00; fq.push_back(8'hF4); send_frame(0);
    @(negedge clk);
    chk("corrupt_valid", 32'(cval[0]), 32'd1);
    chk("corrupt_ok", 32'(cok[0]), 32'd0);
    @(posedge clk); #1;

    crc_ready = 1'b0;
    load_check(); send_frame(0);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("stall_ready", 32'(rdy[0]), 32'd0);
      chk("stall_crc", act_crc(0), 32'hF4);
      @(posedge clk); #1;
    end
    crc_ready = 1'b1;
    send_beat(0, 32'h31, 4'h1, 1'b1); expect_result(0, "stall_next", 32'h97);

    send_beat(0, 32'h31, 4'h1, 1'b0); send_beat(0, 32'h32, 4'h1, 1'b0);
    clr_i = 1'b1; @(posedge clk); #1; clr_i = 1'b0;
    load_check(); send_frame(0); expect_result(0, "after_clr", 32'hF4);

    send_beat(2, 32'h34333231, 4'hF, 1'b0);
    rst_i = 1'b1; @(posedge clk); #1; rst_i = 1'b0;
    check_reset_state("midreset");
    load_check(); send_frame(2); expect_result(2, "after_rst", 32'hCBF43926);

    rnd_en = 1'b1;
    for (int f = 0; f < 250; f++) begin
      int d;
      int nb;
      d  = $urandom_range(0, 2);
      nb = $urandom_range(1, 4);
      for (int b = 0; b < nb; b++) begin
        if ($urandom_range(0, 3) == 0) begin
          crc_ready = ($urandom_range(0, 9) < 7);
          @(posedge clk); #1;
        end
        send_beat(d, $urandom, 4'($urandom_range(0, 15)), (b == nb - 1));
      end
    end
    rnd_en = 1'b0; crc_ready = 1'b1; clr_i = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=running expected=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/crc_engine.md
CRC_ENGINE -- requirements
Module: crc_engine

Interface
REQ-001 SHALL have parameter CRC_W, default 8; CRC width, legal values 8, 16 and 32.
REQ-002 SHALL have parameter POLY, default 'h07; generator polynomial, normal form, implicit top bit.
REQ-003 SHALL have parameter INIT, default 0; register value at frame start.
REQ-004 SHALL have parameter XOR_OUT, default 0; value XORed onto the final register.
REQ-005 SHALL have parameter REFLECT_IN, default 0; if 1, each input byte is bit-reversed before processing.
REQ-006 SHALL have parameter REFLECT_OUT, default 0; if 1, the final register is bit-reversed across CRC_W before XOR_OUT.
REQ-007 SHALL have parameter LANES, default 1; bytes per beat, legal values 1 to 4.
REQ-008 SHALL have parameter RESIDUE, default 0; crc_o value that marks a frame with a good appended CRC.
REQ-009 SHALL have port clk_i, input, 1 bit: clock.
REQ-010 SHALL have port rst_i, input, 1 bit: reset, asynchronous, active-high.
REQ-011 SHALL have port clr_i, input, 1 bit: synchronous abort/clear.
REQ-012 SHALL have port s_data_i, input, 8*LANES bits: beat data, lane 0 in bits [7:0], processed first.
REQ-013 SHALL have port s_keep_i, input, LANES bits: lane-valid mask, honoured only on the last beat.
REQ-014 SHALL have ports s_valid_i (input, 1), s_last_i (input, 1) and s_ready_o (output, 1): input handshake.
REQ-015 SHALL have port crc_o, output, CRC_W bits: final CRC.
REQ-016 SHALL have ports crc_valid_o (output, 1) and crc_ready_i (input, 1): result handshake.
REQ-017 SHALL have port crc_ok_o, output, 1 bit: asserted when crc_o == RESIDUE; valid with crc_valid_o.

Function
REQ-018 SHALL accept a beat when s_valid_i && s_ready_o.
REQ-019 SHALL drive s_ready_o = !crc_valid_o || crc_ready_i; s_ready_o is combinational and back-to-back frames run at full rate.
REQ-020 SHALL implement states IDLE (no frame open), ACCUM (frame open) and DONE (result held, crc_valid_o=1).
REQ-021 SHALL use these transitions: IDLE/DONE -> ACCUM on an accepted non-last beat; IDLE/DONE -> DONE on an accepted last beat (single-beat frame); ACCUM -> DONE on an accepted last beat; DONE -> IDLE on crc_ready_i with no beat accepted.
REQ-022 SHALL load the running register from INIT at the first beat of every frame, with that beat's bytes applied on top of INIT.
REQ-023 SHALL process all LANES bytes of each non-last beat, and on the last beat only the lanes with s_keep_i=1, in ascending lane order.
REQ-024 SHALL treat a last beat with s_keep_i all zero as contributing no bytes.
REQ-025 SHALL compute crc_o = reflect_out(register) ^ XOR_OUT.
REQ-026 SHALL make crc_o and crc_ok_o registered, valid the cycle after the last beat is accepted (latency 1), and held stable while crc_valid_o=1 && !crc_ready_i.
REQ-027 SHALL keep crc_valid_o high for exactly one cycle when crc_ready_i=1 in DONE, and SHALL reassert it for the next frame if that frame's last beat is accepted in the same cycle.
REQ-028 SHALL give clr_i priority over all other inputs: next state IDLE, crc_valid_o=0, and any beat presented in that cycle discarded.
REQ-029 SHALL ignore beats when s_ready_o=0 and SHALL leave the register unchanged without s_valid_i.
REQ-030 SHALL produce for a zero-byte frame crc_o = reflect_out(INIT) ^ XOR_OUT.

Reset
REQ-031 SHALL on rst_i assert: state IDLE, crc_valid_o 0, crc_o 0, crc_ok_o 0, running register INIT, s_ready_o 1.
REQ-032 SHALL on reset mid-frame discard the partial frame; the next accepted beat starts a new frame.

Structure
REQ-033 SHALL place the state-encoding typedef, the legal CRC_W/LANES limits and the reflect helper in shared package crc_pkg.
REQ-034 SHALL use one combinational sub-module, crc_byte_step (CRC_W, POLY), mapping (register, byte) to the next register, instantiated LANES times in a chain.

Verification
REQ-035 SHALL cover: CRC_W=8, POLY 07, INIT 0, LANES=1, "123456789" -> crc_o 0xF4 one cycle after the last beat.
REQ-036 SHALL cover: CRC_W=16, POLY 1021, INIT FFFF, LANES=2, "123456789" with keep 01 on the last beat -> 0x29B1.
REQ-037 SHALL cover: CRC_W=32, POLY 04C11DB7, INIT/XOR_OUT FFFFFFFF, both reflects 1, LANES=4, "123456789" -> 0xCBF43926.
REQ-038 SHALL cover: CRC-8 frame "123456789",0xF4 with RESIDUE 0 -> crc_o 0x00, crc_ok_o 1; corrupted byte -> crc_ok_o 0.
REQ-039 SHALL cover: crc_ready_i held low 5 cycles -> s_ready_o 0 and crc_o stable; then ready with next last beat -> new result next cycle.
REQ-040 SHALL cover: clr_i mid-frame, then "123456789" -> 0xF4 (no residue carried over); rst_i mid-frame -> same behaviour.
